glitch_sequencer: RTL and testbench
===================================

# glitch_sequencer

Multi-channel, trigger-armed pulse sequencer for fault-injection experiments. It is the parametrised successor of the single-channel master/glitch PWM pair. On a synchronised rising edge of an external trigger, it drives up to CHANNELS outputs, each with a runtime offset and width, from one shared timebase. It sits between the button conditioner / target-sync input and the pins that drive the target's clock or supply glitch switch.

## Interface
- CHANNELS, 2: number of independent glitch outputs (1..8).
- CNT_W, 16: width of the timebase and of each offset/width field.
- SYNC_STAGES, 2: flops in the `trig` synchroniser (≥2).
- HOLDOFF, 100: idle cycles enforced after a sequence before returning to IDLE (≥1).
- IDLE_LEVEL, {CHANNELS{1'b0}}: per-channel inactive level of `out`; active level is its inverse.
- clk  in  1  system clock (post-DCM fast clock).
- rst_n  in  1  asynchronous, active-low reset.
- trig  in  1  asynchronous trigger; its rising edge starts a sequence when armed.
- arm  in  1  synchronous one-cycle request: IDLE→ARMED.
- abort  in  1  synchronous; forces IDLE from any state.
- offset  in  CHANNELS*CNT_W  per-channel start offset; channel i is in bits [i*CNT_W +: CNT_W].
- width  in  CHANNELS*CNT_W  per-channel pulse width in cycles; 0 disables the channel.
- out  out  CHANNELS  glitch outputs, registered.
- busy  out  1  high in ARMED, RUN, HOLD.
- done  out  1  one-cycle pulse when the last run of a sequence completes.
- fired  out  8  saturating count of completed sequences.

## Operation
- States are IDLE, ARMED, RUN, HOLD. Reset enters IDLE with `out`=IDLE_LEVEL, `busy`=0, `done`=0, `fired`=0, and the synchroniser and edge flop cleared.
- IDLE: `arm` → ARMED. Trigger edges are ignored.
- ARMED: a detected `trig` rising edge → RUN. `offset` and `width` are latched into shadow registers in the same cycle. The timebase `t` is cleared.
- RUN: `t` increments each cycle. Channel i is active iff offset_i ≤ t < offset_i+width_i, evaluated at CNT_W+1 bits with no wrap. span = max over enabled channels of offset_i+width_i, at CNT_W+1 bits. RUN ends in the cycle where t == span−1; if span==0, RUN lasts exactly one cycle. At the end of RUN: `done` pulses, `fired` increments (saturating at 255), and the FSM moves to HOLD.
- HOLD: counts HOLDOFF cycles with all outputs at IDLE_LEVEL, then → IDLE.
- `abort` has the highest priority. From any state the FSM goes to IDLE next cycle, `out` returns to IDLE_LEVEL next cycle, and `done`/`fired` are unaffected.
- `arm` outside IDLE is ignored. `arm` and `abort` in the same cycle: abort wins.
- Trigger edges in RUN or HOLD are dropped, not queued.
- Overlapping channel windows are legal and independent.

## Timing
- Synchroniser plus edge detector: an edge sampled at clock edge N is flagged at edge N+SYNC_STAGES.
- `out[i]` leaves IDLE_LEVEL at edge N+SYNC_STAGES+2+offset_i. It stays active for exactly width_i cycles.
- `done` is high during the cycle after the last RUN cycle. `busy` falls HOLDOFF cycles after that.
- Changes to `offset`/`width` after the trigger edge have no effect until the next sequence.
- Minimum trig high/low time is 2 clk periods for guaranteed detection.

## Configuration
- `GLITCH_REPEAT_EN` defined:
  - Adds an 8-bit input `repeat_n`, latched with the shadow registers.
  - After a RUN ends, `t` clears and RUN restarts back-to-back, repeat_n additional times, with no idle cycle between runs.
  - `done` and the `fired` increment occur only after the final run.
  - `abort` terminates mid-repeat.
- `GLITCH_REPEAT_EN` undefined: the port is absent and exactly one run occurs per trigger.

## Test plan
- Reset, then arm, SYNC_STAGES=2, ch0 offset=5 width=3, trig rising → out[0] high on edges N+9..N+11; `done` one cycle after; `fired`=1; `busy` falls 100 cycles later.
- Two channels, ch0 offset=0 width=4, ch1 offset=2 width=10 → overlap on t=2..3; RUN length 12; ch1 alone high for 8 cycles after ch0 falls.
- Trig without prior arm, and a second trig during RUN → no extra output activity; `fired` increments only once.
- `abort` asserted at t=3 of a width=20 pulse → `out` back at IDLE_LEVEL next cycle, no `done`, `fired` unchanged; a new arm+trig works normally.
- width=0 on all channels → one RUN cycle, `out` static, `done` pulses, `fired` increments; with `GLITCH_REPEAT_EN`, repeat_n=2 and offset=1 width=1 → three pulses spaced span=2 cycles apart, a single `done`.
- Deassert `rst_n` mid-RUN → `out`=IDLE_LEVEL and `busy`=0 immediately (asynchronous); 256 completed sequences → `fired` holds at 255.

Source files
------------

// File: rtl/glitch_sequencer.sv
// Trigger-armed multi-channel glitch pulse sequencer sharing one timebase.
// Define GLITCH_REPEAT_EN to add the repeat_n input for back-to-back runs.
module glitch_sequencer #(
  parameter int unsigned         CHANNELS    = 2,
  parameter int unsigned         CNT_W       = 16,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         HOLDOFF     = 100,
  parameter logic [CHANNELS-1:0] IDLE_LEVEL  = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trig,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [CHANNELS*CNT_W-1:0] offset,
  input  logic [CHANNELS*CNT_W-1:0] width,
`ifdef GLITCH_REPEAT_EN
  input  logic [7:0]                repeat_n,
`endif
  output logic [CHANNELS-1:0]       out,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                fired
);

  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_HOLD
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nx;
  logic [SYNC_STAGES-1:0]    r_sync;
  logic                      r_trig_d;
  logic                      r_edge;
  logic [CHANNELS*CNT_W-1:0] r_off_sh;
  logic [CHANNELS*CNT_W-1:0] r_wid_sh;
  logic [CNT_W:0]            r_t;
  logic [CNT_W:0]            w_t_nx;
  logic [HOLD_W-1:0]         r_hold;
  logic [HOLD_W-1:0]         w_hold_nx;
  logic [CHANNELS-1:0]       r_out;
  logic                      r_done;
  logic [7:0]                r_fired;
  logic [CNT_W:0]            w_end [CHANNELS];
  logic [CNT_W:0]            w_span;
  logic [CHANNELS-1:0]       w_active;
  logic                      w_run_end;
  logic                      w_more;
  logic                      w_latch;
  logic                      w_finish;

`ifdef GLITCH_REPEAT_EN
  logic [7:0] r_rep;
  logic [7:0] w_rep_nx;

  assign w_more = (r_rep != '0);
`else
  assign w_more = 1'b0;
`endif

  // Edge flag is registered so the FSM reacts SYNC_STAGES+1 edges after sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_trig_d <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], trig};
      r_trig_d <= r_sync[SYNC_STAGES-1];
      r_edge   <= r_sync[SYNC_STAGES-1] & ~r_trig_d;
    end
  end

  // Window ends and span use one extra bit so offset+width never wraps.
  always_comb begin
    w_span   = '0;
    w_active = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_end[i] = {1'b0, r_off_sh[i*CNT_W +: CNT_W]} + {1'b0, r_wid_sh[i*CNT_W +: CNT_W]};
      if ((r_wid_sh[i*CNT_W +: CNT_W] != '0) && (w_end[i] > w_span)) begin
        w_span = w_end[i];
      end
      w_active[i] = ({1'b0, r_off_sh[i*CNT_W +: CNT_W]} <= r_t) && (r_t < w_end[i]);
    end
    w_run_end = (w_span == '0) || (r_t == (w_span - 1'b1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_t_nx     = r_t;
    w_hold_nx  = r_hold;
    w_latch    = 1'b0;
    w_finish   = 1'b0;
`ifdef GLITCH_REPEAT_EN
    w_rep_nx   = r_rep;
`endif
    if (abort) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) w_state_nx = S_ARMED;
        end
        S_ARMED: begin
          if (r_edge) begin
            w_state_nx = S_RUN;
            w_latch    = 1'b1;
            w_t_nx     = '0;
          end
        end
        S_RUN: begin
          if (w_run_end) begin
            w_t_nx = '0;
            if (w_more) begin
`ifdef GLITCH_REPEAT_EN
              w_rep_nx = r_rep - 1'b1;
`endif
            end else begin
              w_state_nx = S_HOLD;
              w_finish   = 1'b1;
              w_hold_nx  = '0;
            end
          end else begin
            w_t_nx = r_t + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_hold == HOLD_W'(HOLDOFF - 1)) begin
            w_state_nx = S_IDLE;
          end else begin
            w_hold_nx = r_hold + 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off_sh <= '0;
      r_wid_sh <= '0;
      r_t      <= '0;
      r_hold   <= '0;
      r_out    <= IDLE_LEVEL;
      r_done   <= 1'b0;
      r_fired  <= '0;
`ifdef GLITCH_REPEAT_EN
      r_rep    <= '0;
`endif
    end else begin
      r_t    <= w_t_nx;
      r_hold <= w_hold_nx;
      r_done <= w_finish;
      if (w_latch) begin
        r_off_sh <= offset;
        r_wid_sh <= width;
      end
`ifdef GLITCH_REPEAT_EN
      if (w_latch) begin
        r_rep <= repeat_n;
      end else begin
        r_rep <= w_rep_nx;
      end
`endif
      if ((r_state == S_RUN) && !abort) begin
        r_out <= IDLE_LEVEL ^ w_active;
      end else begin
        r_out <= IDLE_LEVEL;
      end
      if (w_finish && (r_fired != 8'hFF)) begin
        r_fired <= r_fired + 1'b1;
      end
    end
  end

  assign out   = r_out;
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign fired = r_fired;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: table of channel timings plus
// hand-written abort, reset, no-arm, retrigger and saturation sequences.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic        arm;
  logic        abort;
  logic [31:0] offset;
  logic [31:0] width;
`ifdef GLITCH_REPEAT_EN
  logic [7:0]  repeat_n;
`endif
  logic [1:0]  out;
  logic        busy;
  logic        done;
  logic [7:0]  fired;

  int total = 0;
  int bad   = 0;
  int exp_fired = 0;

  typedef struct {
    logic [15:0] o0, w0, o1, w1;
    int          f0, l0, c0;
    int          f1, l1, c1;
    int          done_k;
    bit          retrig;
  } vec_t;

  vec_t vecs[6];

  glitch_sequencer #(
    .CHANNELS   (2),
    .CNT_W      (16),
    .SYNC_STAGES(2),
    .HOLDOFF    (100),
    .IDLE_LEVEL (2'b00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trig    (trig),
    .arm     (arm),
    .abort   (abort),
    .offset  (offset),
    .width   (width),
`ifdef GLITCH_REPEAT_EN
    .repeat_n(repeat_n),
`endif
    .out     (out),
    .busy    (busy),
    .done    (done),
    .fired   (fired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // k counts samples taken on the negedge after trigger-sampling edge N+k.
  task automatic run_seq(input string tag, input vec_t v);
    int f0, l0, c0, f1, l1, c1, dk, dc, bl;
    f0 = -1; l0 = -1; c0 = 0;
    f1 = -1; l1 = -1; c1 = 0;
    dk = -1; dc = 0; bl = -1;
    @(negedge clk);
    offset = {v.o1, v.o0};
    width  = {v.w1, v.w0};
    arm    = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk({tag, "_armed_busy"}, busy, 1);
    trig = 1'b1;
    for (int k = 0; k < v.done_k + 110; k++) begin
      @(negedge clk);
      if (out[0]) begin if (f0 < 0) f0 = k; l0 = k; c0++; end
      if (out[1]) begin if (f1 < 0) f1 = k; l1 = k; c1++; end
      if (done)   begin if (dk < 0) dk = k; dc++; end
      if (busy) bl = k;
      if (k == 3) trig = 1'b0;
      if (k == 4) begin offset = '0; width = '1; end
      if (v.retrig && k == 8)  trig = 1'b1;
      if (v.retrig && k == 11) trig = 1'b0;
    end
    if (exp_fired < 255) exp_fired++;
    chk({tag, "_ch0_first"}, f0, v.f0);
    chk({tag, "_ch0_last"},  l0, v.l0);
    chk({tag, "_ch0_count"}, c0, v.c0);
    chk({tag, "_ch1_first"}, f1, v.f1);
    chk({tag, "_ch1_last"},  l1, v.l1);
    chk({tag, "_ch1_count"}, c1, v.c1);
    chk({tag, "_done_at"},   dk, v.done_k);
    chk({tag, "_done_cnt"},  dc, 1);
    chk({tag, "_busy_last"}, bl, v.done_k + 99);
    chk({tag, "_fired"},     fired, exp_fired);
  endtask

  task automatic quick_seq();
    @(negedge clk);
    offset = '0;
    width  = '0;
    arm    = 1'b1;
    @(negedge clk);
    arm  = 1'b0;
    trig = 1'b1;
    repeat (4) @(negedge clk);
    trig = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (exp_fired < 255) exp_fired++;
    chk("sat_busy_fall", busy, 0);
  endtask

  initial begin
    int act;
    int hi;
    //       o0     w0     o1     w1     f0  l0  c0  f1  l1  c1  done retrig
    vecs[0] = '{16'd5, 16'd3, 16'd0, 16'd0,  9, 11, 3, -1, -1, 0,  11, 1'b0};
    vecs[1] = '{16'd0, 16'd4, 16'd2, 16'd10, 4,  7, 4,  6, 15, 10, 15, 1'b1};
    vecs[2] = '{16'd0, 16'd0, 16'd0, 16'd0, -1, -1, 0, -1, -1, 0,   4, 1'b0};
    vecs[3] = '{16'd7, 16'd1, 16'd3, 16'd2, 11, 11, 1,  7,  8, 2,  11, 1'b0};
    vecs[4] = '{16'd10, 16'd0, 16'd1, 16'd1, -1, -1, 0, 5,  5, 1,   5, 1'b0};
    vecs[5] = '{16'd0, 16'd1, 16'd0, 16'd1,  4,  4, 1,  4,  4, 1,   4, 1'b0};

    rst_n  = 1'b0;
    trig   = 1'b0;
    arm    = 1'b0;
    abort  = 1'b0;
    offset = '0;
    width  = '0;
`ifdef GLITCH_REPEAT_EN
    repeat_n = '0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_out",   out,   0);
    chk("reset_busy",  busy,  0);
    chk("reset_done",  done,  0);
    chk("reset_fired", fired, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Trigger with no arm: nothing may happen.
    act = 0;
    trig = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 4) trig = 1'b0;
      if (out != 2'b00 || busy || done) act++;
    end
    chk("noarm_activity", act, 0);
    chk("noarm_fired", fired, exp_fired);

    // arm and abort together: abort wins.
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("arm_abort_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_seq($sformatf("row%0d", i), vecs[i]);

    // Abort during a width=20 pulse at t=3.
    @(negedge clk);
    offset = {16'd0, 16'd0};
    width  = {16'd0, 16'd20};
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    trig = 1'b1;
    hi = 0; act = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out[0]) hi++;
      if (done) act++;
      if (k == 3) trig = 1'b0;
      if (k == 6) abort = 1'b1;
      if (k == 7) begin
        chk("abort_out_next", out, 0);
        chk("abort_busy_next", busy, 0);
        abort = 1'b0;
      end
    end
    chk("abort_high_cycles", hi, 3);
    chk("abort_no_done", act, 0);
    chk("abort_fired", fired, exp_fired);
    run_seq("after_abort", vecs[0]);

`ifdef GLITCH_REPEAT_EN
    begin
      vec_t rv;
      rv = '{16'd1, 16'd1, 16'd0, 16'd0, 5, 9, 3, -1, -1, 0, 9, 1'b0};
      repeat_n = 8'd2;
      run_seq("repeat", rv);
      repeat_n = 8'd0;
    end
`endif

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    offset = {16'd0, 16'd0};
    width  = {16'd0, 16'd20};
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    trig = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) trig = 1'b0;
    end
    chk("prereset_out0", out[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out",   out,   0);
    chk("async_rst_busy",  busy,  0);
    chk("async_rst_fired", fired, 0);
    exp_fired = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Saturation of the fired counter.
    for (int i = 0; i < 256; i++) begin
      quick_seq();
      if (i == 254) chk("fired_at_255", fired, exp_fired);
    end
    chk("fired_saturated", fired, exp_fired);
    chk("fired_is_255", fired, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
